// File: rtl/fetch_step_if.sv
// fetch_step_if: groups the fetch stage's instruction-memory request/response
// channel, the execute redirect, and the fetch->decode handshake.
// master = fetch stage side, slave = memory/execute/decode environment side.
// Optional macro FETCH_PERF_COUNTER_EN adds the delivered-instruction counter.
interface fetch_step_if;
  logic        bellek_istek_gecerli_o;
  logic        bellek_istek_hazir_i;
  logic [31:0] bellek_adres_o;
  logic        bellek_yanit_gecerli_i;
  logic [31:0] bellek_yanit_veri_i;
  logic        dallanma_gecerli_i;
  logic [31:0] dallanma_adres_i;
  logic        stall_i;
  logic        getir_gecerli_o;
  logic [31:0] getir_buyruk_o;
  logic [31:0] getir_ps_o;
`ifdef FETCH_PERF_COUNTER_EN
  logic [31:0] getir_sayac_o;
`endif

  modport master (
    output bellek_istek_gecerli_o,
    input  bellek_istek_hazir_i,
    output bellek_adres_o,
    input  bellek_yanit_gecerli_i,
    input  bellek_yanit_veri_i,
    input  dallanma_gecerli_i,
    input  dallanma_adres_i,
    input  stall_i,
    output getir_gecerli_o,
    output getir_buyruk_o,
    output getir_ps_o
`ifdef FETCH_PERF_COUNTER_EN
    ,
    output getir_sayac_o
`endif
  );

  modport slave (
    input  bellek_istek_gecerli_o,
    output bellek_istek_hazir_i,
    input  bellek_adres_o,
    output bellek_yanit_gecerli_i,
    output bellek_yanit_veri_i,
    output dallanma_gecerli_i,
    output dallanma_adres_i,
    output stall_i,
    input  getir_gecerli_o,
    input  getir_buyruk_o,
    input  getir_ps_o
`ifdef FETCH_PERF_COUNTER_EN
    ,
    input  getir_sayac_o
`endif
  );
endinterface

// File: rtl/fetch_step.sv
// fetch_step: fetch stage. Owns the PC, issues in-order word reads to
// instruction memory under a credit limit (outstanding + buffered <= FIFO_DEPTH),
// buffers returned words with their PCs and hands the FIFO head to decode.
// A redirect from execute flushes the buffer and discards responses that were
// already in flight when it happened.
// Optional macro FETCH_PERF_COUNTER_EN: adds getir_sayac_o, a wrapping count of
// instructions accepted by decode.
module fetch_step #(
  parameter logic [31:0] RESET_PC   = 32'h0000_0000,
  parameter int          FIFO_DEPTH = 4
) (
  input  logic         clk_i,
  input  logic         rst_i,
  fetch_step_if.master bus
);

  localparam int CW = $clog2(FIFO_DEPTH) + 1;  // counter width, holds 0..FIFO_DEPTH
  localparam int AW = $clog2(FIFO_DEPTH);      // FIFO pointer width

  typedef enum logic [1:0] {
    BASLAT  = 2'b00,  // one settling cycle after reset release
    CALIS   = 2'b01,  // normal fetching
    TEMIZLE = 2'b10   // waiting for stale responses to drain
  } state_t;

  state_t         state;
  logic [31:0]    pc;           // address of the next request
  logic [CW-1:0]  outstanding;  // requests accepted but not yet answered
  logic [CW-1:0]  drop;         // responses still to be discarded after a redirect
  logic [CW-1:0]  count;        // FIFO occupancy
  logic [AW-1:0]  rd_ptr;
  logic [AW-1:0]  wr_ptr;
  logic [31:0]    buyruk_mem [FIFO_DEPTH];
  logic [31:0]    ps_mem     [FIFO_DEPTH];

  logic [CW:0]    credit_used;
  logic           redirect;
  logic           req_valid;
  logic           accept;
  logic           resp;
  logic           push;
  logic           pop;
  logic [CW-1:0]  out_after_resp;
  logic [31:0]    resp_pc;
  logic [31:0]    target_pc;
  logic           unused_target_bits;

  // Low target bits are forced to 00; this only absorbs them.
  assign unused_target_bits = ^bus.dallanma_adres_i[1:0];

  // Request/response/handshake qualifiers derived from current state.
  always_comb begin
    redirect       = bus.dallanma_gecerli_i;
    credit_used    = {1'b0, outstanding} + {1'b0, count};
    req_valid      = 1'b0;
    accept         = 1'b0;
    resp           = 1'b0;
    push           = 1'b0;
    pop            = 1'b0;
    out_after_resp = outstanding;
    target_pc      = {bus.dallanma_adres_i[31:2], 2'b00};
    // Oldest in-flight request: pc has already advanced once per outstanding request.
    resp_pc        = pc - (32'(outstanding) << 2);

    if ((state == CALIS) && !redirect && (credit_used < (CW+1)'(FIFO_DEPTH))) begin
      req_valid = 1'b1;
    end else begin
      req_valid = 1'b0;
    end

    accept = req_valid && bus.bellek_istek_hazir_i;

    // A response with nothing outstanding is spurious and ignored.
    if (bus.bellek_yanit_gecerli_i && (outstanding != CW'(0))) begin
      resp           = 1'b1;
      out_after_resp = outstanding - CW'(1);
    end else begin
      resp           = 1'b0;
      out_after_resp = outstanding;
    end

    // Keep the word only when it is not stale and no redirect is flushing now.
    if (resp && (drop == CW'(0)) && !redirect) begin
      push = 1'b1;
    end else begin
      push = 1'b0;
    end

    if ((count != CW'(0)) && !bus.stall_i) begin
      pop = 1'b1;
    end else begin
      pop = 1'b0;
    end
  end

  // Control FSM: state, PC, outstanding-request and stale-drop counters.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state       <= BASLAT;
      pc          <= RESET_PC;
      outstanding <= CW'(0);
      drop        <= CW'(0);
    end else if (redirect) begin
      // No request can be accepted in a redirect cycle, so only the response matters.
      pc          <= target_pc;
      outstanding <= out_after_resp;
      drop        <= out_after_resp;
      if (out_after_resp != CW'(0)) begin
        state <= TEMIZLE;
      end else begin
        state <= CALIS;
      end
    end else begin
      case ({accept, resp})
        2'b10:   outstanding <= outstanding + CW'(1);
        2'b01:   outstanding <= outstanding - CW'(1);
        default: outstanding <= outstanding;
      endcase

      if (accept) begin
        pc <= pc + 32'd4;
      end else begin
        pc <= pc;
      end

      if (resp && (drop != CW'(0))) begin
        drop <= drop - CW'(1);
      end else begin
        drop <= drop;
      end

      case (state)
        BASLAT: begin
          state <= CALIS;
        end
        CALIS: begin
          state <= CALIS;
        end
        TEMIZLE: begin
          if (resp && (drop == CW'(1))) begin
            state <= CALIS;
          end else begin
            state <= TEMIZLE;
          end
        end
        default: begin
          state <= BASLAT;
        end
      endcase
    end
  end

  // FIFO bookkeeping: pointers and occupancy; a redirect empties the buffer.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      rd_ptr <= AW'(0);
      wr_ptr <= AW'(0);
      count  <= CW'(0);
    end else if (redirect) begin
      rd_ptr <= AW'(0);
      wr_ptr <= AW'(0);
      count  <= CW'(0);
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + AW'(1);
      end else begin
        wr_ptr <= wr_ptr;
      end

      if (pop) begin
        rd_ptr <= rd_ptr + AW'(1);
      end else begin
        rd_ptr <= rd_ptr;
      end

      case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  // FIFO storage: cleared on reset so the decode outputs read zero until filled.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        buyruk_mem[i] <= 32'h0000_0000;
        ps_mem[i]     <= 32'h0000_0000;
      end
    end else if (push) begin
      buyruk_mem[wr_ptr] <= bus.bellek_yanit_veri_i;
      ps_mem[wr_ptr]     <= resp_pc;
    end else begin
      buyruk_mem[wr_ptr] <= buyruk_mem[wr_ptr];
      ps_mem[wr_ptr]     <= ps_mem[wr_ptr];
    end
  end

`ifdef FETCH_PERF_COUNTER_EN
  logic [31:0] sayac;

  // Count every instruction decode accepts; wraps naturally.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      sayac <= 32'h0000_0000;
    end else if (pop) begin
      sayac <= sayac + 32'd1;
    end else begin
      sayac <= sayac;
    end
  end

  assign bus.getir_sayac_o = sayac;
`else
`endif

  assign bus.bellek_istek_gecerli_o = req_valid;
  assign bus.bellek_adres_o         = pc;
  assign bus.getir_gecerli_o        = (count != CW'(0));
  assign bus.getir_buyruk_o         = buyruk_mem[rd_ptr];
  assign bus.getir_ps_o             = ps_mem[rd_ptr];

endmodule
